// File: rtl/parity_gen.sv
// Even/odd parity generator plus receive-side parity checker, one-cycle latency each.
// Define PARITY_STATS_EN to add saturating tx_cnt / err_cnt statistics outputs.
module parity_gen #(
  parameter int DATA_W  = 7,
  parameter bit PAR_MSB = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              p,
  input  logic [DATA_W-1:0] tt_in,
  input  logic              in_valid,
  output logic [DATA_W:0]   pdata,
  output logic              out_valid,
  input  logic [DATA_W:0]   rx_data,
  input  logic              rx_valid,
  output logic              rx_err,
  output logic              rx_err_valid
`ifdef PARITY_STATS_EN
  ,
  output logic [15:0]       tx_cnt,
  output logic [15:0]       err_cnt
`endif
);

  logic              w_tx_par;
  logic              w_rx_err;
  logic [DATA_W:0]   w_pword;

  logic [DATA_W:0]   r_pdata;
  logic              r_out_valid;
  logic              r_rx_err;
  logic              r_rx_err_valid;

  assign w_tx_par = (^tt_in) ^ p;
  assign w_rx_err = (^rx_data) ^ p;

  generate
    if (PAR_MSB) begin : g_par_msb
      assign w_pword = {w_tx_par, tt_in};
    end else begin : g_par_lsb
      assign w_pword = {tt_in, w_tx_par};
    end
  endgenerate

  // Data registers only load on their valid so they hold between words.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pdata        <= '0;
      r_out_valid    <= 1'b0;
      r_rx_err       <= 1'b0;
      r_rx_err_valid <= 1'b0;
    end else begin
      r_out_valid    <= in_valid;
      r_rx_err_valid <= rx_valid;
      if (in_valid) r_pdata  <= w_pword;
      if (rx_valid) r_rx_err <= w_rx_err;
    end
  end

  assign pdata        = r_pdata;
  assign out_valid    = r_out_valid;
  assign rx_err       = r_rx_err;
  assign rx_err_valid = r_rx_err_valid;

`ifdef PARITY_STATS_EN
  logic [15:0] r_tx_cnt;
  logic [15:0] r_err_cnt;

  // Counters saturate rather than wrap so a long run never reports a small count.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_tx_cnt  <= '0;
      r_err_cnt <= '0;
    end else begin
      if (in_valid && (r_tx_cnt != 16'hFFFF))
        r_tx_cnt <= r_tx_cnt + 16'd1;
      if (rx_valid && w_rx_err && (r_err_cnt != 16'hFFFF))
        r_err_cnt <= r_err_cnt + 16'd1;
    end
  end

  assign tx_cnt  = r_tx_cnt;
  assign err_cnt = r_err_cnt;
`endif

endmodule

// File: tb/tb_parity_gen.sv
// Scoreboard bench for parity_gen: expected words queued at drive time, popped on output valids.
module tb_parity_gen;
  localparam int DATA_W = 7;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              p = 1'b0;
  logic [DATA_W-1:0] tt_in = '0;
  logic              in_valid = 1'b0;
  logic [DATA_W:0]   pdata;
  logic              out_valid;
  logic [DATA_W:0]   rx_data = '0;
  logic              rx_valid = 1'b0;
  logic              rx_err;
  logic              rx_err_valid;
`ifdef PARITY_STATS_EN
  logic [15:0]       tx_cnt;
  logic [15:0]       err_cnt;
`endif

  parity_gen #(.DATA_W(DATA_W), .PAR_MSB(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .p(p), .tt_in(tt_in), .in_valid(in_valid),
    .pdata(pdata), .out_valid(out_valid), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_err(rx_err), .rx_err_valid(rx_err_valid)
`ifdef PARITY_STATS_EN
    , .tx_cnt(tx_cnt), .err_cnt(err_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [DATA_W:0] model(input logic [DATA_W-1:0] d, input logic pm);
    return {(^d) ^ pm, d};
  endfunction

  logic [DATA_W:0] txq[$];
  logic            rxq[$];
  logic            mon_en = 1'b0;
  logic            exp_ov = 1'b0;
  logic            exp_rv = 1'b0;
  logic [DATA_W:0] last_pdata = '0;
  logic            last_err = 1'b0;

  // Reference for valid timing: a result appears one edge after its qualifying valid.
  always @(posedge clk) begin
    exp_ov = rst_n & in_valid;
    exp_rv = rst_n & rx_valid;
    if (!rst_n) begin
      last_pdata = '0;
      last_err   = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (mon_en) begin
      chk("out_valid", 32'(out_valid), 32'(exp_ov));
      chk("rx_err_valid", 32'(rx_err_valid), 32'(exp_rv));
      if (out_valid) begin
        if (txq.size() > 0) begin
          last_pdata = txq.pop_front();
          chk("pdata", 32'(pdata), 32'(last_pdata));
        end else chk("tx_underflow", 32'(out_valid), 32'd0);
      end else chk("pdata_hold", 32'(pdata), 32'(last_pdata));
      if (rx_err_valid) begin
        if (rxq.size() > 0) begin
          last_err = rxq.pop_front();
          chk("rx_err", 32'(rx_err), 32'(last_err));
        end else chk("rx_underflow", 32'(rx_err_valid), 32'd0);
      end else chk("rx_err_hold", 32'(rx_err), 32'(last_err));
    end
  end

  // One clock of stimulus; expectations are queued only for words that will be serviced.
  task automatic tick(input logic iv, input logic [DATA_W-1:0] d, input logic pm,
                      input logic [DATA_W:0] exp_pd, input logic rv,
                      input logic [DATA_W:0] rd, input logic exp_e);
    @(posedge clk); #1;
    in_valid = iv; tt_in = d; p = pm; rx_valid = rv; rx_data = rd;
    if (iv && rst_n) txq.push_back(exp_pd);
    if (rv && rst_n) rxq.push_back(exp_e);
  endtask

  task automatic idle();
    tick(1'b0, '0, p, '0, 1'b0, '0, 1'b0);
  endtask

  initial begin
    logic pm;
    // Reset held two clocks with valids asserted: nothing may emerge.
    in_valid = 1'b1; rx_valid = 1'b1; tt_in = 7'h55; rx_data = 8'h01;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_pdata", 32'(pdata), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_rx_err", 32'(rx_err), 32'd0);
    chk("rst_rx_err_valid", 32'(rx_err_valid), 32'd0);
    mon_en = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b1; in_valid = 1'b0; rx_valid = 1'b0;

    // Directed generate + concurrent check, even then odd.
    tick(1'b1, 7'h03, 1'b0, 8'h03, 1'b1, 8'h81, 1'b0);
    tick(1'b1, 7'h01, 1'b0, 8'h81, 1'b1, 8'h80, 1'b1);
    idle();
    tick(1'b1, 7'h00, 1'b1, 8'h80, 1'b0, '0, 1'b0);
    tick(1'b1, 7'h7F, 1'b1, 8'h7F, 1'b1, 8'h80, 1'b0);
    tick(1'b0, 7'h12, 1'b1, '0, 1'b1, 8'h81, 1'b1);
    idle(); idle();

    // Streaming with p flipping every 3 clocks.
    for (int i = 0; i < 16; i++) begin
      pm = ((i / 3) % 2) != 0;
      tick(1'b1, 7'(i), pm, model(7'(i), pm), 1'b0, '0, 1'b0);
    end
    idle();

    // Loopback: each generated word fed back into the checker with the same p.
    for (int i = 0; i <= 128; i++) begin
      @(posedge clk); #1;
      p = 1'b0;
      rx_data = pdata; rx_valid = out_valid;
      if (out_valid) rxq.push_back(1'b0);
      in_valid = (i < 128);
      tt_in = 7'(i);
      if (i < 128) txq.push_back(model(7'(i), 1'b0));
    end
    idle(); idle();

`ifdef PARITY_STATS_EN
    @(posedge clk); #1; rst_n = 1'b0;
    @(posedge clk); #1; rst_n = 1'b1;
    tick(1'b1, 7'h03, 1'b0, 8'h03, 1'b1, 8'h80, 1'b1);
    tick(1'b1, 7'h01, 1'b0, 8'h81, 1'b1, 8'h81, 1'b0);
    tick(1'b1, 7'h00, 1'b0, 8'h00, 1'b1, 8'h01, 1'b1);
    tick(1'b1, 7'h7F, 1'b0, 8'hFF, 1'b0, '0, 1'b0);
    tick(1'b1, 7'h05, 1'b0, 8'h05, 1'b0, '0, 1'b0);
    idle();
    @(negedge clk);
    chk("tx_cnt", 32'(tx_cnt), 32'd5);
    chk("err_cnt", 32'(err_cnt), 32'd2);
    tick(1'b1, 7'h11, 1'b0, 8'h11, 1'b1, 8'h80, 1'b1);
    @(posedge clk); #1;
    rst_n = 1'b0; in_valid = 1'b1; rx_valid = 1'b1; rx_data = 8'h80;
    @(negedge clk);
    chk("tx_cnt_rst", 32'(tx_cnt), 32'd0);
    chk("err_cnt_rst", 32'(err_cnt), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1; in_valid = 1'b0; rx_valid = 1'b0;
    idle();
`endif

    idle(); idle();
    @(negedge clk);
    chk("txq_drained", 32'(txq.size()), 32'd0);
    chk("rxq_drained", 32'(rxq.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end
endmodule
